// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch path.
// rv32i_types holds ISA-level word/entry types; fetch_queue_types holds the
// fetch queue controller state encoding and PC arithmetic helpers.

package rv32i_types;

    typedef logic [31:0] word_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;

endpackage

package fetch_queue_types;

    import rv32i_types::*;

    // IDLE: no request outstanding.
    // FETCH: request outstanding, response will be pushed.
    // DISCARD: request outstanding but made stale by a redirect, so the response is dropped.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fq_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Sequential next PC; wraps naturally at the top of the 32-bit space.
    function automatic word_t next_pc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Circular buffer of DEPTH {pc, inst} entries with push, pop, clear,
// combinational head outputs and an occupancy count.

module fq_storage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_inst,
    input  logic                     pop,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_mem_q [DEPTH];
    logic [31:0]      pc_mem_d [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      inst_mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Guarded push/pop and pointer/count updates; clear wins over both.
    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Write the incoming entry into the tail slot.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (push_ok && !clear) begin
            pc_mem_d[tail_q]   = push_pc;
            inst_mem_d[tail_q] = push_inst;
        end
    end

    // Pointer and count registers, zeroed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: slots are only read once counted valid.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

    assign head_pc   = pc_mem_q[head_q];
    assign head_inst = inst_mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues at most one memory read at a time, pushes
// returned words into fq_storage, and handles redirects by flushing the queue
// and dropping any response belonging to the stale request.

module fetch_queue
    import rv32i_types::*;
    import fetch_queue_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            mem_address,
    output logic                   mem_read,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_resp,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_pc,
    output logic [31:0]            deq_inst,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fq_state_t        state_q, state_d;
    word_t            fetch_pc_q, fetch_pc_d;
    word_t            req_addr_q, req_addr_d;
    logic             sq_push;
    logic             sq_pop;
    logic             sq_clear;
    logic [CNT_W-1:0] occ_after_pop;
    logic [CNT_W-1:0] occ_after_push;

    // Next-state, fetch PC and request address; redirect outranks push and pop.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_addr_d     = req_addr_q;
        sq_push        = 1'b0;
        sq_clear       = 1'b0;
        mem_read       = 1'b0;
        sq_pop         = deq_valid && deq_ready && !redirect;
        occ_after_pop  = count - CNT_W'(sq_pop);
        occ_after_push = occ_after_pop + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    sq_clear   = 1'b1;
                    fetch_pc_d = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = FETCH;
                end else if (occ_after_pop < CNT_W'(DEPTH)) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                mem_read = 1'b1;
                if (redirect) begin
                    sq_clear   = 1'b1;
                    fetch_pc_d = redirect_pc;
                    if (mem_resp) begin
                        req_addr_d = redirect_pc;
                        state_d    = FETCH;
                    end else begin
                        state_d    = DISCARD;
                    end
                end else if (mem_resp) begin
                    sq_push    = 1'b1;
                    fetch_pc_d = next_pc(fetch_pc_q);
                    if (occ_after_push < CNT_W'(DEPTH)) begin
                        req_addr_d = next_pc(fetch_pc_q);
                        state_d    = FETCH;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end

            DISCARD: begin
                mem_read = 1'b1;
                if (redirect) begin
                    sq_clear   = 1'b1;
                    fetch_pc_d = redirect_pc;
                end
                if (mem_resp) begin
                    req_addr_d = redirect ? redirect_pc : fetch_pc_q;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            mem_read = 1'b0;
        end
    end

    // Controller registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fq_storage #(
        .DEPTH(DEPTH)
    ) u_storage (
        .clk       (clk),
        .rst       (rst),
        .clear     (sq_clear),
        .push      (sq_push),
        .push_pc   (fetch_pc_q),
        .push_inst (mem_rdata),
        .pop       (sq_pop),
        .head_pc   (deq_pc),
        .head_inst (deq_inst),
        .count     (count)
    );

    assign mem_address = req_addr_q;
    assign deq_valid   = (count != '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected queue entries.

module tb_fetch_queue;

    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic [2:0]  count;

    fetch_entry_t sb[$];
    int           n_assert;
    int           n_fail;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_inst    (deq_inst),
        .count       (count)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for a read request, check its address, return one response.
    task automatic applyStimulus(input logic [31:0] addr, input bit expect_push, input string tag);
        int waited = 0;
        while (mem_read !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_read"}, {31'b0, mem_read}, 32'd1);
        checkOutput({tag, "_addr"}, mem_address, addr);
        mem_resp  = 1'b1;
        mem_rdata = inst_of(addr);
        if (expect_push) begin
            sb.push_back('{pc: addr, inst: inst_of(addr)});
        end
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    // Check the head against the scoreboard and accept it for one cycle.
    task automatic popHead(input string tag);
        fetch_entry_t e;
        e = '1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end
        checkOutput({tag, "_valid"}, {31'b0, deq_valid}, 32'd1);
        checkOutput({tag, "_pc"}, deq_pc, e.pc);
        checkOutput({tag, "_inst"}, deq_inst, e.inst);
        deq_ready = 1'b1;
        @(negedge clk);
        deq_ready = 1'b0;
    endtask

    task automatic pulseRedirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        sb.delete();
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        mem_rdata   = '0;
        mem_resp    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        deq_ready   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", {31'b0, deq_valid}, 32'd0);
        checkOutput("rst_read", {31'b0, mem_read}, 32'd0);
        rst = 1'b0;

        // Fill: back-to-back responses until the queue is full.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h60 + 32'(4 * i), 1'b1, "fill");
        end
        checkOutput("full_read", {31'b0, mem_read}, 32'd0);
        checkOutput("full_count", 32'(count), 32'd4);
        @(negedge clk);
        checkOutput("full_hold_read", {31'b0, mem_read}, 32'd0);

        // One pop from a full queue reopens a slot for exactly one request.
        popHead("pop_full");
        checkOutput("pop_count", 32'(count), 32'd3);
        applyStimulus(32'h70, 1'b1, "refill");
        checkOutput("refill_count", 32'(count), 32'd4);
        checkOutput("refill_read", {31'b0, mem_read}, 32'd0);

        // Drain; fetching of 0x74 starts and is left outstanding.
        for (int i = 0; i < 4; i++) begin
            popHead("drain");
        end
        checkOutput("drain_count", 32'(count), 32'd0);
        checkOutput("drain_valid", {31'b0, deq_valid}, 32'd0);

        // Redirect while 0x74 outstanding: old address held, data dropped.
        pulseRedirect(32'h60);
        checkOutput("disc74_addr", mem_address, 32'h74);
        applyStimulus(32'h74, 1'b0, "drop74");
        applyStimulus(32'h60, 1'b1, "re60");
        applyStimulus(32'h64, 1'b1, "re64");
        checkOutput("pre200_count", 32'(count), 32'd2);

        // Redirect to 0x200 while 0x68 outstanding.
        pulseRedirect(32'h200);
        checkOutput("r200_count", 32'(count), 32'd0);
        checkOutput("r200_valid", {31'b0, deq_valid}, 32'd0);
        checkOutput("r200_hold_addr", mem_address, 32'h68);
        @(negedge clk);
        checkOutput("r200_hold_addr2", mem_address, 32'h68);
        applyStimulus(32'h68, 1'b0, "drop68");
        checkOutput("drop68_valid", {31'b0, deq_valid}, 32'd0);
        applyStimulus(32'h200, 1'b1, "f200");
        checkOutput("f200_visible", {31'b0, deq_valid}, 32'd1);
        checkOutput("f200_pc", deq_pc, 32'h200);

        // Redirect coincident with response (and a pop request): nothing kept.
        checkOutput("r400_pre_addr", mem_address, 32'h204);
        mem_resp    = 1'b1;
        mem_rdata   = inst_of(32'h204);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        deq_ready   = 1'b1;
        sb.delete();
        @(negedge clk);
        mem_resp  = 1'b0;
        redirect  = 1'b0;
        deq_ready = 1'b0;
        checkOutput("r400_count", 32'(count), 32'd0);
        checkOutput("r400_read", {31'b0, mem_read}, 32'd1);
        checkOutput("r400_addr", mem_address, 32'h400);
        applyStimulus(32'h400, 1'b1, "f400");

        // Simultaneous push and pop keeps the count.
        checkOutput("pp_pre_addr", mem_address, 32'h404);
        checkOutput("pp_head", deq_pc, 32'h400);
        void'(sb.pop_front());
        sb.push_back('{pc: 32'h404, inst: inst_of(32'h404)});
        mem_resp  = 1'b1;
        mem_rdata = inst_of(32'h404);
        deq_ready = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        deq_ready = 1'b0;
        checkOutput("pp_count", 32'(count), 32'd1);
        checkOutput("pp_head_pc", deq_pc, sb[0].pc);
        checkOutput("pp_head_inst", deq_inst, sb[0].inst);

        // Reset with 0x408 outstanding restarts at the reset PC.
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("mrst_read", {31'b0, mem_read}, 32'd0);
        checkOutput("mrst_count", 32'(count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mrst_valid", {31'b0, deq_valid}, 32'd0);
        applyStimulus(32'h60, 1'b1, "post_rst");
        checkOutput("post_rst_valid", {31'b0, deq_valid}, 32'd1);

        // Second redirect in DISCARD only moves the restart PC; then wrap.
        pulseRedirect(32'h800);
        checkOutput("d2_addr", mem_address, 32'h64);
        pulseRedirect(32'hFFFF_FFFC);
        checkOutput("d3_addr", mem_address, 32'h64);
        checkOutput("d3_read", {31'b0, mem_read}, 32'd1);
        applyStimulus(32'h64, 1'b0, "drop64");
        applyStimulus(32'hFFFF_FFFC, 1'b1, "wrap_hi");
        applyStimulus(32'h0000_0000, 1'b1, "wrap_lo");
        popHead("pop_hi");
        popHead("pop_lo");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000060, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_address  output  32  instruction memory address.
REQ-006 SHALL have port mem_read  output  1  read request, held until mem_resp.
REQ-007 SHALL have port mem_rdata  input  32  returned instruction word.
REQ-008 SHALL have port mem_resp  input  1  one-cycle completion strobe.
REQ-009 SHALL have port redirect  input  1  flush and restart fetch (branch/jump resolution).
REQ-010 SHALL have port redirect_pc  input  32  restart address, sampled when redirect=1.
REQ-011 SHALL have port deq_valid  output  1  head entry available.
REQ-012 SHALL have port deq_ready  input  1  decode accepts head.
REQ-013 SHALL have port deq_pc  output  32  PC of head entry.
REQ-014 SHALL have port deq_inst  output  32  instruction of head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DISCARD.
REQ-017 SHALL drive mem_read=1 in FETCH and DISCARD only; mem_address SHALL remain constant from assertion until mem_resp.
REQ-018 SHALL hold at most one outstanding memory request.
REQ-019 SHALL, in IDLE, enter FETCH with mem_address=fetch_pc next cycle when post-cycle occupancy < DEPTH and redirect=0.
REQ-020 SHALL, in FETCH on mem_resp without redirect, push {fetch_pc, mem_rdata}, set fetch_pc += 4 (32-bit wrap), stay in FETCH if post-cycle occupancy < DEPTH, else go to IDLE.
REQ-021 SHALL, on redirect in FETCH without mem_resp, empty queue, load fetch_pc=redirect_pc, go to DISCARD.
REQ-022 SHALL, on redirect coincident with mem_resp in FETCH, discard returned data (no push), empty queue, load fetch_pc=redirect_pc, go to FETCH.
REQ-023 SHALL, in DISCARD, keep old address until mem_resp, drop the data, then go to FETCH at fetch_pc; a further redirect in DISCARD only updates fetch_pc.
REQ-024 SHALL, on redirect in IDLE, empty queue, load fetch_pc=redirect_pc, go to FETCH.
REQ-025 SHALL assert deq_valid iff count != 0; deq_pc/deq_inst SHALL be combinational from head entry.
REQ-026 SHALL pop when deq_valid && deq_ready; simultaneous push and pop leaves count unchanged.
REQ-027 SHALL give redirect priority over pop and push in the same cycle.
REQ-028 SHALL never overflow (push only into a slot reserved at issue) nor underflow.
REQ-029 SHALL make a pushed entry visible on deq_valid the cycle after mem_resp.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, fetch_pc=RESET_PC, count=0, head/tail pointers=0, mem_read=0, deq_valid=0.
REQ-031 SHALL, when rst asserts mid-request, abandon it without push; first post-reset request is at RESET_PC.

Structure
REQ-032 SHALL place the FSM state enum in a shared package (fetch_queue_types), alongside rv32i_types.
REQ-033 SHALL use one sub-module, fq_storage: DEPTH-entry circular buffer with push, pop, clear, head outputs and count.

Verification
REQ-034 SHALL cover reset then mem_resp each cycle, deq_ready=0: four requests at 0x60,0x64,0x68,0x6C, then mem_read=0, count=4.
REQ-035 SHALL cover full queue, deq_ready pulsed one cycle: count 4->3, one new request at 0x70, count returns to 4.
REQ-036 SHALL cover redirect to 0x200 while request to 0x68 outstanding: count=0, 0x68 held until resp, data dropped, next request at 0x200.
REQ-037 SHALL cover redirect to 0x400 coincident with mem_resp: no push, count=0, next cycle mem_address=0x400.
REQ-038 SHALL cover rst during outstanding request: next request at 0x60, deq_valid=0 until first new resp.
REQ-039 SHALL cover fetch_pc=0xFFFFFFFC resp: next request at 0x00000000.
